e_md_unit: RTL and testbench
============================

Name: e_md_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage; owns the HI/LO registers.
- Produces the MD data value that the M-stage write-back/forward mux selects when the instruction class is MD read (mfhi/mflo).
- Exposes Busy so the hazard unit stalls D while any MD instruction waits on an operation in flight.
- Accepts an exception/interrupt request that suppresses new side effects.

Parameters:
- MULT_CYCLES, 5, Busy duration in cycles for mult/multu (minimum 1).
- DIV_CYCLES, 10, Busy duration in cycles for div/divu (minimum 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge clears all state.
- E_MDOp  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9–15 none.
- E_Start  input  1  one-cycle qualifier for E_MDOp 1–4 (launch).
- E_RS  input  32  operand A (dividend) / mthi / mtlo source.
- E_RT  input  32  operand B (divisor).
- Req  input  1  exception/interrupt flush: blocks launch and mthi/mtlo in this cycle.
- E_Busy  output  1  operation in flight.
- E_HI  output  32  current HI register.
- E_LO  output  32  current LO register.
- E_MDData  output  32  read result: HI when E_MDOp==5, LO when E_MDOp==6, else 0.

Behaviour:
- Reset (reset==0 at an edge):
  - HI, LO, counter and result temporaries go to 0.
  - E_Busy=0, E_MDData=0.
  - Reset takes priority over everything and aborts any in-flight operation.
- Launch condition: E_Start=1, E_MDOp in 1–4, counter==0, Req=0, sampled at an edge.
  - At that edge the full result is computed from E_RS/E_RT into temp_hi/temp_lo.
  - Counter loads MULT_CYCLES for mult/multu, or DIV_CYCLES for div/divu.
- E_Busy = (counter != 0), registered.
  - E_Busy is high for exactly N cycles following the launch edge.
  - Counter decrements by 1 at each edge while nonzero.
- At the edge where the counter goes 1→0, HI<=temp_hi and LO<=temp_lo.
  - The new values are visible in the first cycle with E_Busy=0.
  - Latency launch-edge to HI/LO visible = N edges.
- Arithmetic:
  - mult: signed 32x32→64; {HI,LO}=product.
  - multu: unsigned 32x32→64; {HI,LO}=product.
  - div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned; LO=quotient; HI=remainder.
  - Signed div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo (E_MDOp 7/8):
  - Write HI/LO from E_RS at the edge when counter==0 and Req=0.
  - While busy, they are ignored; the hazard unit guarantees this does not occur.
- mfhi/mflo: E_MDData is combinational from the current HI/LO, with no added latency.
- E_Start while busy: ignored; the in-flight operation is unaffected and no restart occurs.
- Req=1:
  - Launch and mthi/mtlo in the same cycle are suppressed.
  - An operation already in flight continues and commits HI/LO normally, since it belongs to an older, committed instruction.
- Launch while the counter goes 1→0 in the same cycle: not possible, because counter==0 is required for launch. The launch is accepted on the following edge.

Optional Feature:
- Macro: MD_DIV_ZERO_KEEP_EN
- Defined: div/divu with E_RT==0 still assert Busy for DIV_CYCLES, but HI and LO are left unchanged at completion.
- Not defined: divide-by-zero commits a fixed result:
  - divu: LO=0xFFFFFFFF, HI=E_RS.
  - div: LO=0xFFFFFFFF if E_RS>=0, else 0x00000001; HI=E_RS.
  - Never X.

Test Plan:
- Reset released, then mult RS=0xFFFFFFFF RT=0x00000002 → Busy high 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE; E_MDOp=5 gives E_MDData=0xFFFFFFFF.
- multu, same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div RS=0xFFFFFFF9 (−7) RT=2 → Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu RS=7 RT=2 → LO=3, HI=1.
- Launch mult, then pulse E_Start with div during cycle 2 of Busy → ignored; Busy still drops after 5 cycles with the mult result. Then mthi RS=0x12345678 with Req=1 → HI unchanged; repeated with Req=0 → HI=0x12345678.
- Launch div; reset=0 during the 4th busy cycle → next cycle Busy=0, HI=LO=0; no commit afterwards.
- div RS=5 RT=0 → with MD_DIV_ZERO_KEEP_EN, HI/LO keep prior values; without it, LO=0xFFFFFFFF, HI=5.

Source files
------------

// File: rtl/e_md_unit_if.sv
// rtl/e_md_unit_if.sv - E-stage multiply/divide request/result bundle
interface e_md_unit_if;
  logic [3:0]  E_MDOp;
  logic        E_Start;
  logic [31:0] E_RS;
  logic [31:0] E_RT;
  logic        Req;
  logic        E_Busy;
  logic [31:0] E_HI;
  logic [31:0] E_LO;
  logic [31:0] E_MDData;

  modport master (
    output E_MDOp, E_Start, E_RS, E_RT, Req,
    input  E_Busy, E_HI, E_LO, E_MDData
  );

  modport slave (
    input  E_MDOp, E_Start, E_RS, E_RT, Req,
    output E_Busy, E_HI, E_LO, E_MDData
  );
endinterface

// File: rtl/e_md_unit.sv
// rtl/e_md_unit.sv - multi-cycle mult/div unit owning HI/LO (optional MD_DIV_ZERO_KEEP_EN)
module e_md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  e_md_unit_if.slave  md
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt;
  logic          busy;
  logic [31:0]   hi, lo, temp_hi, temp_lo;
  logic [31:0]   rs, rt;
  logic [63:0]   prod_s, prod_u;
  logic          a_neg, b_neg, rt_zero;
  logic [31:0]   a_mag, b_mag, safe_b, safe_rt;
  logic [31:0]   q_mag, r_mag, div_q, div_r, divu_q, divu_r;
  logic [31:0]   res_hi, res_lo;
  logic          is_launch, is_div;
`ifdef MD_DIV_ZERO_KEEP_EN
  logic          keep;
`endif

  assign rs = md.E_RS;
  assign rt = md.E_RT;

  // Low 64 bits of a sign-extended product equal the signed product.
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Signed divide through magnitudes; divisor forced to 1 on zero so nothing goes X.
  assign rt_zero = (rt == 32'd0);
  assign a_neg   = rs[31];
  assign b_neg   = rt[31];
  assign a_mag   = a_neg ? (32'd0 - rs) : rs;
  assign b_mag   = b_neg ? (32'd0 - rt) : rt;
  assign safe_b  = rt_zero ? 32'd1 : b_mag;
  assign safe_rt = rt_zero ? 32'd1 : rt;
  assign q_mag   = a_mag / safe_b;
  assign r_mag   = a_mag % safe_b;
  assign div_q   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign div_r   = a_neg ? (32'd0 - r_mag) : r_mag;
  assign divu_q  = rs / safe_rt;
  assign divu_r  = rs % safe_rt;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (md.E_MDOp)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV:   {res_hi, res_lo} = rt_zero ? {rs, (a_neg ? 32'h0000_0001 : 32'hFFFF_FFFF)}
                                           : {div_r, div_q};
      OP_DIVU:  {res_hi, res_lo} = rt_zero ? {rs, 32'hFFFF_FFFF} : {divu_r, divu_q};
      default:  ;
    endcase
  end

  assign is_launch = md.E_Start && (md.E_MDOp >= OP_MULT) && (md.E_MDOp <= OP_DIVU);
  assign is_div    = (md.E_MDOp == OP_DIV) || (md.E_MDOp == OP_DIVU);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      temp_hi <= 32'd0;
      temp_lo <= 32'd0;
`ifdef MD_DIV_ZERO_KEEP_EN
      keep    <= 1'b0;
`endif
    end else if (cnt != '0) begin
      // In-flight work always completes; Req only affects new side effects.
      cnt  <= cnt - CW'(1);
      busy <= (cnt != CW'(1));
      if (cnt == CW'(1)) begin
`ifdef MD_DIV_ZERO_KEEP_EN
        if (!keep) begin
          hi <= temp_hi;
          lo <= temp_lo;
        end
`else
        hi <= temp_hi;
        lo <= temp_lo;
`endif
      end
    end else if (!md.Req) begin
      if (is_launch) begin
        temp_hi <= res_hi;
        temp_lo <= res_lo;
        cnt     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        busy    <= 1'b1;
`ifdef MD_DIV_ZERO_KEEP_EN
        keep    <= is_div && rt_zero;
`endif
      end else if (md.E_MDOp == OP_MTHI) begin
        hi <= rs;
      end else if (md.E_MDOp == OP_MTLO) begin
        lo <= rs;
      end
    end
  end

  always_comb begin
    md.E_MDData = 32'd0;
    if (md.E_MDOp == OP_MFHI)      md.E_MDData = hi;
    else if (md.E_MDOp == OP_MFLO) md.E_MDData = lo;
  end

  assign md.E_Busy = busy;
  assign md.E_HI   = hi;
  assign md.E_LO   = lo;
endmodule

// File: tb/tb_e_md_unit.sv
// tb/tb_e_md_unit.sv - bench for e_md_unit with arithmetic reference model
module tb_e_md_unit;
  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  e_md_unit_if md_bus ();
  e_md_unit dut (.clk(clk), .reset(reset), .md(md_bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Expected HI/LO straight from the arithmetic definitions.
  task automatic model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    case (op)
      4'd1: begin sq = sa * sb; {m_hi, m_lo} = sq; end
      4'd2: begin up = ua * ub; {m_hi, m_lo} = up; end
      4'd3: begin
        if (rt == 32'd0) begin
`ifndef MD_DIV_ZERO_KEEP_EN
          m_lo = (sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
          m_hi = rs;
`endif
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          m_lo = sq[31:0];
          m_hi = sr[31:0];
        end
      end
      4'd4: begin
        if (rt == 32'd0) begin
`ifndef MD_DIV_ZERO_KEEP_EN
          m_lo = 32'hFFFF_FFFF;
          m_hi = rs;
`endif
        end else begin
          up = ua / ub;
          m_lo = up[31:0];
          up = ua % ub;
          m_hi = up[31:0];
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_reads(input string tag);
    check({tag, ".hi"}, md_bus.E_HI, m_hi);
    check({tag, ".lo"}, md_bus.E_LO, m_lo);
    md_bus.E_MDOp = 4'd5; #1;
    check({tag, ".mfhi"}, md_bus.E_MDData, m_hi);
    md_bus.E_MDOp = 4'd6; #1;
    check({tag, ".mflo"}, md_bus.E_MDData, m_lo);
    md_bus.E_MDOp = 4'd0; #1;
  endtask

  // Launch op, count busy cycles; inject_at>0 pulses a div launch plus Req in that busy cycle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int inject_at);
    int n, cnt;
    n = (op >= 4'd3) ? 10 : 5;
    md_bus.E_MDOp = op; md_bus.E_Start = 1'b1; md_bus.E_RS = rs; md_bus.E_RT = rt;
    tick();
    md_bus.E_MDOp = 4'd0; md_bus.E_Start = 1'b0;
    check({tag, ".pre"}, md_bus.E_HI, m_hi);
    model(op, rs, rt);
    cnt = 0;
    while (md_bus.E_Busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == inject_at) begin
        md_bus.E_MDOp = 4'd3; md_bus.E_Start = 1'b1; md_bus.Req = 1'b1;
        md_bus.E_RS = $urandom; md_bus.E_RT = $urandom;
      end
      tick();
      md_bus.E_MDOp = 4'd0; md_bus.E_Start = 1'b0; md_bus.Req = 1'b0;
    end
    check({tag, ".busy_cycles"}, 32'(cnt), 32'(n));
    check_reads(tag);
  endtask

  task automatic move_to(input string tag, input logic [3:0] op, input logic [31:0] rs,
                         input logic req);
    md_bus.E_MDOp = op; md_bus.E_RS = rs; md_bus.Req = req;
    tick();
    md_bus.E_MDOp = 4'd0; md_bus.Req = 1'b0;
    if (!req) begin
      if (op == 4'd7) m_hi = rs;
      else m_lo = rs;
    end
    check({tag, ".hi"}, md_bus.E_HI, m_hi);
    check({tag, ".lo"}, md_bus.E_LO, m_lo);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] rrs, rrt;
    reset = 1'b0;
    md_bus.E_MDOp = 4'd0; md_bus.E_Start = 1'b0; md_bus.Req = 1'b0;
    md_bus.E_RS = 32'd0; md_bus.E_RT = 32'd0;
    tick(); tick();
    reset = 1'b1;
    check("reset.busy", {31'd0, md_bus.E_Busy}, 32'd0);
    check_reads("reset");

    run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op("divu", 4'd4, 32'h0000_0007, 32'h0000_0002, 0);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("mult_inject", 4'd1, 32'h1234_5678, 32'h9ABC_DEF0, 2);

    move_to("mthi_req", 4'd7, 32'h1234_5678, 1'b1);
    move_to("mthi", 4'd7, 32'h1234_5678, 1'b0);
    move_to("mtlo", 4'd8, 32'hCAFE_F00D, 1'b0);

    // A launch during Req must not start anything.
    md_bus.E_MDOp = 4'd1; md_bus.E_Start = 1'b1; md_bus.Req = 1'b1;
    md_bus.E_RS = 32'd3; md_bus.E_RT = 32'd4;
    tick();
    md_bus.E_MDOp = 4'd0; md_bus.E_Start = 1'b0; md_bus.Req = 1'b0;
    check("req_launch.busy", {31'd0, md_bus.E_Busy}, 32'd0);
    repeat (6) tick();
    check_reads("req_launch");

    md_bus.E_MDOp = 4'd9; #1;
    check("mddata_none", md_bus.E_MDData, 32'd0);
    md_bus.E_MDOp = 4'd0;

    // Reset during the 4th busy cycle of a div aborts it.
    md_bus.E_MDOp = 4'd3; md_bus.E_Start = 1'b1; md_bus.E_RS = 32'd100; md_bus.E_RT = 32'd7;
    tick();
    md_bus.E_MDOp = 4'd0; md_bus.E_Start = 1'b0;
    tick(); tick(); tick();
    check("abort.busy_before", {31'd0, md_bus.E_Busy}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    check("abort.busy", {31'd0, md_bus.E_Busy}, 32'd0);
    check_reads("abort");
    repeat (12) tick();
    check_reads("abort_later");

    move_to("pre_dz_hi", 4'd7, 32'hAAAA_0001, 1'b0);
    move_to("pre_dz_lo", 4'd8, 32'h5555_0002, 1'b0);
    run_op("div_zero", 4'd3, 32'd5, 32'd0, 0);
    run_op("div_zero_neg", 4'd3, 32'hFFFF_FFF0, 32'd0, 0);
    run_op("divu_zero", 4'd4, 32'h8000_0001, 32'd0, 0);

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(1, 4));
      rrs = $urandom;
      case ($urandom_range(0, 5))
        0:       rrt = 32'd0;
        1:       rrt = 32'($urandom_range(1, 9));
        2:       rrt = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rrt = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) rrs = 32'($urandom_range(0, 50));
      run_op("rand", rop, rrs, rrt, ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
